// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter: round-robin sharing of one 16-bit rotate shifter among
// N valid/ready requesters, with a single registered, index-tagged result slot.

// Combinational 16-bit rotator. A right rotate is done as a left rotate of the
// bit-reversed operand, reversed back, so one log-stage left rotator serves both.
module barrel_shifter_rev_16 (
  input  logic [15:0] a,
  input  logic [3:0]  amt,
  input  logic        lr,
  output logic [15:0] y
);

  logic [15:0] rot;

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // Log-stage left rotate, wrapped in optional bit reversal for right rotates.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output
    // before any conditional update, so no latch can be inferred.
    rot = lr ? rev16(a) : a;
    for (int s = 0; s < 4; s++) begin
      if (amt[s]) rot = (rot << (1 << s)) | (rot >> (16 - (1 << s)));
    end
    y = lr ? rev16(rot) : rot;
  end

endmodule

module barrel_shift_arbiter #(
  parameter int N  = 4,
  parameter int W  = 16,
  parameter int AW = 4,
  parameter int IW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*W-1:0]  req_a,
  input  logic [N*AW-1:0] req_amt,
  input  logic [N-1:0]    req_lr,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [W-1:0]    res_y,
  output logic [IW-1:0]   res_id
);

  typedef enum logic {EMPTY, FULL} slot_state_e;

  localparam logic [IW:0] N_W = (IW + 1)'(N);

  slot_state_e       state, state_nxt;
  logic [IW-1:0]     last;
  logic [N-1:0]      grant;
  logic [IW-1:0]     grant_idx;
  logic              found;
  logic [IW:0]       cand;
  logic              slot_free;
  logic              take;
  logic [W-1:0]      a_sel;
  logic [AW-1:0]     amt_sel;
  logic              lr_sel;
  logic [W-1:0]      shift_y;

  // Round-robin search: first valid requester starting just after 'last'.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last} + (IW + 1)'(k);
      if (cand >= N_W) cand = cand - N_W;
      if (!found && req_valid[cand[IW-1:0]]) begin
        found            = 1'b1;
        grant_idx        = cand[IW-1:0];
        grant[grant_idx] = 1'b1;
      end
    end
  end

  // The output slot can take a new result when empty or being drained now;
  // nothing is accepted while reset is asserted.
  assign slot_free = (state == EMPTY) | res_ready;
  assign req_ready = (slot_free && !reset) ? grant : '0;
  assign take      = |req_ready;
  assign res_valid = (state == FULL);

  // Steer the granted requester's operand, amount and direction to the shifter.
  always_comb begin
    a_sel   = '0;
    amt_sel = '0;
    lr_sel  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        a_sel   = req_a[i*W +: W];
        amt_sel = req_amt[i*AW +: AW];
        lr_sel  = req_lr[i];
      end
    end
  end

  barrel_shifter_rev_16 u_shifter (
    .a   (a_sel),
    .amt (amt_sel),
    .lr  (lr_sel),
    .y   (shift_y)
  );

  // Result-slot state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking '<=' so every
    // register samples pre-edge values regardless of statement order.
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Slot next state: any grant fills it, a drain without a grant empties it.
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (take) state_nxt = FULL;
      FULL:  if (take) state_nxt = FULL;
             else if (res_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Capture the rotated result and tag; advance the pointer only on a transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_y  <= '0;
      res_id <= '0;
      last   <= IW'(N - 1);
    end else if (take) begin
      res_y  <= shift_y;
      res_id <= grant_idx;
      last   <= grant_idx;
    end
  end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Self-checking bench for barrel_shift_arbiter: a cycle model of the slot and
// round-robin pointer checks every cycle, plus vector tables and directed
// sequences for the documented corner cases.
module tb_barrel_shift_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int AW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a;
  logic [N*AW-1:0] req_amt;
  logic [N-1:0]    req_lr;
  logic            res_valid;
  logic            res_ready;
  logic [W-1:0]    res_y;
  logic [IW-1:0]   res_id;

  barrel_shift_arbiter #(.N(N), .W(W), .AW(AW), .IW(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_amt   (req_amt),
    .req_lr    (req_lr),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_y     (res_y),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int          m_last;
  logic        m_valid;
  logic [15:0] m_y;
  int          m_id;
  int          tick_grant;

  typedef struct {
    int          req;
    logic [15:0] a;
    logic [3:0]  amt;
    logic        lr;
    logic [15:0] exp_y;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Rotate by concatenating the operand with itself and shifting.
  function automatic logic [15:0] rot_ref(input logic [15:0] a, input int amt, input logic lr);
    logic [31:0] d;
    d = {a, a};
    if (lr) begin
      d = d >> (amt % 16);
      return d[15:0];
    end
    d = d << (amt % 16);
    return d[31:16];
  endfunction

  function automatic int model_grant();
    for (int k = 1; k <= N; k++) begin
      if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  // One clock: check outputs against the model mid-low-phase, then step the model.
  task automatic tick();
    int g;
    logic [N-1:0] exp_ready;
    #1;
    g = model_grant();
    exp_ready = '0;
    if (!reset && (!m_valid || res_ready) && g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("res_valid", 32'(res_valid), 32'(m_valid));
    check("res_y", 32'(res_y), 32'(m_y));
    check("res_id", 32'(res_id), m_id);
    tick_grant = (exp_ready != '0) ? g : -1;
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0;
      m_y     = '0;
      m_id    = 0;
      m_last  = N - 1;
    end else if (tick_grant >= 0) begin
      m_y     = rot_ref(req_a[tick_grant*W +: W], int'(req_amt[tick_grant*AW +: AW]), req_lr[tick_grant]);
      m_id    = tick_grant;
      m_valid = 1'b1;
      m_last  = tick_grant;
    end else if (res_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic [15:0] a, input logic [3:0] amt, input logic lr);
    req_a[r*W +: W]    = a;
    req_amt[r*AW +: AW] = amt;
    req_lr[r]          = lr;
    req_valid[r]       = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int exp_seq[6];
    logic [15:0] sweep_a[3];
    logic [15:0] held_y;
    exp_seq  = '{0, 1, 2, 3, 0, 1};
    sweep_a  = '{16'h0000, 16'h0001, 16'h2465};

    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_amt   = '0;
    req_lr    = '0;
    res_ready = 1'b0;
    m_valid   = 1'b0;
    m_y       = '0;
    m_id      = 0;
    m_last    = N - 1;
    @(negedge clk);
    @(negedge clk);

    // Reset state, with a request pending: req_ready must stay low.
    set_req(0, 16'h1234, 4'd3, 1'b0);
    tick();
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_res_y", 32'(res_y), 32'd0);
    req_valid = '0;
    reset = 1'b0;

    // Vector table: spec vectors, then exhaustive sweep on requester 1.
    vecs.push_back('{0, 16'h2465, 4'd4, 1'b1, 16'h5246});
    vecs.push_back('{2, 16'h2465, 4'd4, 1'b0, 16'h4652});
    vecs.push_back('{2, 16'h0001, 4'd15, 1'b0, 16'h8000});
    vecs.push_back('{2, 16'h0001, 4'd1, 1'b1, 16'h8000});
    for (int ai = 0; ai < 3; ai++)
      for (int amt = 0; amt < 16; amt++)
        for (int lr = 0; lr < 2; lr++)
          vecs.push_back('{1, sweep_a[ai], 4'(amt), 1'(lr), rot_ref(sweep_a[ai], amt, 1'(lr))});

    res_ready = 1'b1;
    foreach (vecs[i]) begin
      set_req(vecs[i].req, vecs[i].a, vecs[i].amt, vecs[i].lr);
      #1;
      check("vec_ready", 32'(req_ready), 32'(1 << vecs[i].req));
      tick();
      req_valid = '0;
      check("vec_y", 32'(res_y), 32'(vecs[i].exp_y));
      check("vec_id", 32'(res_id), 32'(vecs[i].req));
      check("vec_valid", 32'(res_valid), 32'd1);
      tick();
    end

    // Fairness / wrap-around: all requesters continuously valid.
    do_reset();
    for (int r = 0; r < N; r++) set_req(r, 16'(16'h0101 * (r + 1)), 4'(r), 1'(r % 2));
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_valid", 32'(res_valid), 32'd1);
      check("rr_id", 32'(res_id), 32'(exp_seq[i]));
    end
    req_valid = '0;
    tick();

    // Backpressure with requesters 1 and 3 valid.
    do_reset();
    set_req(1, 16'h00F0, 4'd2, 1'b0);
    set_req(3, 16'h8001, 4'd1, 1'b1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    held_y = res_y;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_y", 32'(res_y), 32'(held_y));
      check("bp_id", 32'(res_id), 32'd1);
      check("bp_valid", 32'(res_valid), 32'd1);
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'b1000);
    tick();
    check("bp_release_valid", 32'(res_valid), 32'd1);
    check("bp_release_id", 32'(res_id), 32'd3);
    check("bp_release_y", 32'(res_y), 32'h0000C000);

    // Reset mid-stream while the slot is full and stalled.
    res_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_valid", 32'(res_valid), 32'd0);
    check("rst_mid_y", 32'(res_y), 32'd0);
    check("rst_mid_id", 32'(res_id), 32'd0);
    req_valid = '0;
    set_req(2, 16'h2465, 4'd4, 1'b1);
    set_req(3, 16'h2465, 4'd4, 1'b0);
    tick();
    check("rst_first_id", 32'(res_id), 32'd2);
    req_valid = '0;
    res_ready = 1'b1;
    tick();

    // Randomized traffic against the model, with held requests and stalls.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < N; r++) begin
        if (!req_valid[r] && $urandom_range(0, 1) == 1)
          set_req(r, 16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      res_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) == 0);
      tick();
      if (reset) req_valid = '0;
      else if (tick_grant >= 0) req_valid[tick_grant] = 1'b0;
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
